// File: rtl/adder_tree5_sequencer_if.sv
// Handshake, result and shared-tree signals between adder_tree5_sequencer and its surroundings.
// The sequencer connects through the slave modport; the producer/consumer/tree side uses master.
interface adder_tree5_sequencer_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] i_data_a0, i_data_a1, i_data_a2, i_data_a3, i_data_a4, i_data_a5;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] o_data_a0, o_data_a1, o_data_a2, o_data_a3, o_data_a4, o_data_a5;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_tree_a0, o_tree_a1, o_tree_a2, o_tree_a3, o_tree_a4;
  logic              o_tree_enable;
  logic [DATA_W-1:0] i_tree_result;
  logic              o_busy;

  modport slave (
    input  i_data_a0, i_data_a1, i_data_a2, i_data_a3, i_data_a4, i_data_a5,
    input  i_valid, i_ready, i_tree_result,
    output o_ready, o_valid, o_busy, o_tree_enable,
    output o_data_a0, o_data_a1, o_data_a2, o_data_a3, o_data_a4, o_data_a5,
    output o_tree_a0, o_tree_a1, o_tree_a2, o_tree_a3, o_tree_a4
  );

  modport master (
    output i_data_a0, i_data_a1, i_data_a2, i_data_a3, i_data_a4, i_data_a5,
    output i_valid, i_ready, i_tree_result,
    input  o_ready, o_valid, o_busy, o_tree_enable,
    input  o_data_a0, o_data_a1, o_data_a2, o_data_a3, o_data_a4, o_data_a5,
    input  o_tree_a0, o_tree_a1, o_tree_a2, o_tree_a3, o_tree_a4
  );
endinterface

// File: rtl/adder_tree5_sequencer.sv
// Time-multiplexes one shared pipelined adder_tree5 across the six leave-one-out sums
// of a 6-word vector; results are collected and handed out as one vector.
module adder_tree5_sequencer #(
  parameter int DATA_W       = 16,
  parameter int TREE_LATENCY = 3
) (
  input logic                   i_clock,
  input logic                   i_reset,
  adder_tree5_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

  state_t                  state_q;
  logic [DATA_W-1:0]       vec_q     [6];
  logic [DATA_W-1:0]       result_q  [6];
  logic [DATA_W-1:0]       treeOp_q  [5];
  logic [DATA_W-1:0]       inVec     [6];
  logic [2:0]              issueSlot_q;
  logic [2:0]              captureSlot_q;
  logic [TREE_LATENCY-1:0] tokPipe_q;
  logic [TREE_LATENCY-1:0] tokPipe_d;
  logic                    ready_q;
  logic                    valid_q;
  logic                    treeEnable_q;
  logic                    capture;

  assign inVec[0] = bus.i_data_a0;
  assign inVec[1] = bus.i_data_a1;
  assign inVec[2] = bus.i_data_a2;
  assign inVec[3] = bus.i_data_a3;
  assign inVec[4] = bus.i_data_a4;
  assign inVec[5] = bus.i_data_a5;

  // A token marks each issued slot; it leaves the pipe exactly when the tree presents that slot's sum.
  always_comb begin
    tokPipe_d    = '0;
    tokPipe_d[0] = (state_q == ISSUE);
    for (int i = 1; i < TREE_LATENCY; i++) begin
      tokPipe_d[i] = tokPipe_q[i-1];
    end
    capture = treeEnable_q & tokPipe_q[TREE_LATENCY-1];
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= IDLE;
      issueSlot_q   <= '0;
      captureSlot_q <= '0;
      tokPipe_q     <= '0;
      ready_q       <= 1'b0;
      valid_q       <= 1'b0;
      treeEnable_q  <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        vec_q[i]    <= '0;
        result_q[i] <= '0;
      end
      for (int j = 0; j < 5; j++) begin
        treeOp_q[j] <= '0;
      end
    end else begin
      if (treeEnable_q) begin
        tokPipe_q <= tokPipe_d;
      end
      if (capture) begin
        result_q[captureSlot_q] <= bus.i_tree_result;
        captureSlot_q           <= captureSlot_q + 3'd1;
      end

      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && bus.i_valid) begin
            vec_q         <= inVec;
            issueSlot_q   <= '0;
            captureSlot_q <= '0;
            ready_q       <= 1'b0;
            treeEnable_q  <= 1'b1;
            state_q       <= ISSUE;
            for (int j = 0; j < 5; j++) begin
              treeOp_q[j] <= (j == 0) ? inVec[5] : inVec[j];
            end
          end
        end
        ISSUE: begin
          if (issueSlot_q == 3'd5) begin
            state_q <= DRAIN;
            for (int j = 0; j < 5; j++) begin
              treeOp_q[j] <= '0;
            end
          end else begin
            issueSlot_q <= issueSlot_q + 3'd1;
            // Slot k swaps a5 into lane k; slot 5 matches no lane and so sums a0..a4.
            for (int j = 0; j < 5; j++) begin
              treeOp_q[j] <= (j == int'(issueSlot_q) + 1) ? vec_q[5] : vec_q[j];
            end
          end
        end
        DRAIN: begin
          if (capture && captureSlot_q == 3'd5) begin
            treeEnable_q <= 1'b0;
            valid_q      <= 1'b1;
            state_q      <= HOLD;
          end
        end
        HOLD: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_ready       = ready_q;
  assign bus.o_valid       = valid_q;
  assign bus.o_busy        = (state_q != IDLE);
  assign bus.o_tree_enable = treeEnable_q;
  assign bus.o_tree_a0     = treeOp_q[0];
  assign bus.o_tree_a1     = treeOp_q[1];
  assign bus.o_tree_a2     = treeOp_q[2];
  assign bus.o_tree_a3     = treeOp_q[3];
  assign bus.o_tree_a4     = treeOp_q[4];
  assign bus.o_data_a0     = result_q[0];
  assign bus.o_data_a1     = result_q[1];
  assign bus.o_data_a2     = result_q[2];
  assign bus.o_data_a3     = result_q[3];
  assign bus.o_data_a4     = result_q[4];
  assign bus.o_data_a5     = result_q[5];

endmodule

// File: tb/tb_adder_tree5_sequencer.sv
// Directed, table-driven bench for adder_tree5_sequencer with behavioural adder_tree5 models
// at TREE_LATENCY 3 and 1.
module tb_adder_tree5_sequencer;

  typedef struct packed {
    logic [5:0][15:0] a;
    logic [5:0][15:0] e;
  } vec_t;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  adder_tree5_sequencer_if #(.DATA_W(16)) ifc3 ();
  adder_tree5_sequencer_if #(.DATA_W(16)) ifc1 ();

  adder_tree5_sequencer #(.DATA_W(16), .TREE_LATENCY(3)) dut3 (
    .i_clock(clk), .i_reset(rst), .bus(ifc3.slave)
  );
  adder_tree5_sequencer #(.DATA_W(16), .TREE_LATENCY(1)) dut1 (
    .i_clock(clk), .i_reset(rst), .bus(ifc1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural adder_tree5 models: sum mod 2^16, advancing only when enabled, sharing reset.
  logic [15:0] sum3, sum1;
  logic [15:0] tree3 [3];
  logic [15:0] tree1;
  assign sum3 = ifc3.o_tree_a0 + ifc3.o_tree_a1 + ifc3.o_tree_a2 + ifc3.o_tree_a3 + ifc3.o_tree_a4;
  assign sum1 = ifc1.o_tree_a0 + ifc1.o_tree_a1 + ifc1.o_tree_a2 + ifc1.o_tree_a3 + ifc1.o_tree_a4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) tree3[i] <= '0;
      tree1 <= '0;
    end else begin
      if (ifc3.o_tree_enable) begin
        tree3[0] <= sum3;
        tree3[1] <= tree3[0];
        tree3[2] <= tree3[1];
      end
      if (ifc1.o_tree_enable) tree1 <= sum1;
    end
  end
  assign ifc3.i_tree_result = tree3[2];
  assign ifc1.i_tree_result = tree1;

  function automatic vec_t mk(input logic [15:0] a0, a1, a2, a3, a4, a5,
                              input logic [15:0] e0, e1, e2, e3, e4, e5);
    vec_t v;
    v.a = {a5, a4, a3, a2, a1, a0};
    v.e = {e5, e4, e3, e2, e1, e0};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [5:0][15:0] outVec3();
    return {ifc3.o_data_a5, ifc3.o_data_a4, ifc3.o_data_a3,
            ifc3.o_data_a2, ifc3.o_data_a1, ifc3.o_data_a0};
  endfunction

  function automatic logic [5:0][15:0] outVec1();
    return {ifc1.o_data_a5, ifc1.o_data_a4, ifc1.o_data_a3,
            ifc1.o_data_a2, ifc1.o_data_a1, ifc1.o_data_a0};
  endfunction

  task automatic setData3(input vec_t v);
    ifc3.i_data_a0 = v.a[0]; ifc3.i_data_a1 = v.a[1]; ifc3.i_data_a2 = v.a[2];
    ifc3.i_data_a3 = v.a[3]; ifc3.i_data_a4 = v.a[4]; ifc3.i_data_a5 = v.a[5];
  endtask

  // Presents a vector at a falling edge and waits (bounded) until the sequencer is ready for it.
  task automatic applyStimulus(input vec_t v, input logic readyVal, input string tag);
    int waitCnt;
    @(negedge clk);
    setData3(v);
    ifc3.i_valid = 1'b1;
    ifc3.i_ready = readyVal;
    waitCnt = 0;
    while (!ifc3.o_ready && waitCnt < 60) begin
      @(negedge clk);
      waitCnt++;
    end
    check({tag, "_accept"}, 32'(ifc3.o_ready), 32'd1);
  endtask

  // Follows the cycles after an accept edge until o_valid (cycle 1 = first falling edge after it).
  task automatic collect(input logic nextValid, input vec_t nextVec,
                         output int vc, output int en, output int busy);
    vc = -1; en = 0; busy = 0;
    for (int n = 1; n <= 30 && vc < 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        ifc3.i_valid = nextValid;
        if (nextValid) setData3(nextVec);
      end
      if (ifc3.o_tree_enable) en++;
      if (ifc3.o_busy) busy++;
      if (ifc3.o_valid) vc = n;
    end
  endtask

  task automatic checkOutput(input vec_t v, input logic [5:0][15:0] got, input string tag);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s_d%0d", tag, i), 32'(got[i]), 32'(v.e[i]));
    end
  endtask

  vec_t tbl [5];
  vec_t none;

  initial begin
    int vc, en, busy, errs, accIdx, resIdx, enTotal, vSeen;
    int acc [3];
    logic pendingSwitch;
    passed = 0; total = 0;
    none = '0;
    tbl[0] = mk(1, 2, 3, 4, 5, 6, 20, 19, 18, 17, 16, 15);
    tbl[1] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                16'hFFFB, 16'hFFFB, 16'hFFFB, 16'hFFFB, 16'hFFFB, 16'hFFFB);
    tbl[2] = mk(10, 20, 30, 40, 50, 60, 200, 190, 180, 170, 160, 150);
    tbl[3] = mk(0, 0, 0, 0, 0, 100, 100, 100, 100, 100, 100, 0);
    tbl[4] = mk(16'h8000, 16'h8000, 1, 2, 3, 4, 16'h800A, 16'h800A, 9, 8, 7, 6);

    setData3(none);
    ifc3.i_valid = 1'b0; ifc3.i_ready = 1'b0;
    ifc1.i_data_a0 = '0; ifc1.i_data_a1 = '0; ifc1.i_data_a2 = '0;
    ifc1.i_data_a3 = '0; ifc1.i_data_a4 = '0; ifc1.i_data_a5 = '0;
    ifc1.i_valid = 1'b0; ifc1.i_ready = 1'b0;

    // Reset state and the first ready edge after release.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ifc3.o_ready), 32'd0);
    check("rst_valid", 32'(ifc3.o_valid), 32'd0);
    check("rst_busy", 32'(ifc3.o_busy), 32'd0);
    check("rst_en", 32'(ifc3.o_tree_enable), 32'd0);
    check("rst_data", 32'(outVec3()), 32'd0);
    check("rst_tree_a0", 32'(ifc3.o_tree_a0), 32'd0);
    rst = 1'b0;
    #1 check("rel_ready_low", 32'(ifc3.o_ready), 32'd0);
    @(negedge clk);
    check("rel_ready_high", 32'(ifc3.o_ready), 32'd1);

    // Table of single vectors with the consumer always ready.
    for (int t = 0; t < 5; t++) begin
      applyStimulus(tbl[t], 1'b1, $sformatf("v%0d", t));
      collect(1'b0, none, vc, en, busy);
      check($sformatf("v%0d_valid_cycle", t), 32'(vc), 32'd10);
      check($sformatf("v%0d_en_cycles", t), 32'(en), 32'd9);
      check($sformatf("v%0d_busy_cycles", t), 32'(busy), 32'd10);
      checkOutput(tbl[t], outVec3(), $sformatf("v%0d", t));
      @(negedge clk);
      check($sformatf("v%0d_valid_1cyc", t), 32'(ifc3.o_valid), 32'd0);
      check($sformatf("v%0d_ready_back", t), 32'(ifc3.o_ready), 32'd1);
      check($sformatf("v%0d_busy_off", t), 32'(ifc3.o_busy), 32'd0);
    end

    // Backpressure: consumer stalls 20 cycles while a second vector waits.
    applyStimulus(tbl[0], 1'b0, "bp");
    collect(1'b1, tbl[2], vc, en, busy);
    check("bp_valid_cycle", 32'(vc), 32'd10);
    errs = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ifc3.o_valid !== 1'b1 || ifc3.o_ready !== 1'b0 || outVec3() !== tbl[0].e) errs++;
    end
    check("bp_stable_errs", 32'(errs), 32'd0);
    checkOutput(tbl[0], outVec3(), "bp_first");
    ifc3.i_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_after", 32'(ifc3.o_ready), 32'd1);
    check("bp_valid_after", 32'(ifc3.o_valid), 32'd0);
    collect(1'b0, none, vc, en, busy);
    check("bp_second_cycle", 32'(vc), 32'd10);
    checkOutput(tbl[2], outVec3(), "bp_second");
    @(negedge clk);

    // Streaming three vectors with valid and ready held high.
    setData3(tbl[0]);
    ifc3.i_valid = 1'b1; ifc3.i_ready = 1'b1;
    accIdx = 0; resIdx = 0; enTotal = 0; pendingSwitch = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (t > 0) @(negedge clk);
      if (pendingSwitch) begin
        pendingSwitch = 1'b0;
        if (accIdx < 3) setData3(tbl[accIdx]);
        else ifc3.i_valid = 1'b0;
      end
      if (ifc3.o_tree_enable) enTotal++;
      if (ifc3.o_valid && resIdx < 3) begin
        checkOutput(tbl[resIdx], outVec3(), $sformatf("st%0d", resIdx));
        resIdx++;
      end
      if (ifc3.o_ready && ifc3.i_valid && accIdx < 3) begin
        acc[accIdx] = t;
        accIdx++;
        pendingSwitch = 1'b1;
      end
    end
    check("st_accepts", 32'(accIdx), 32'd3);
    check("st_results", 32'(resIdx), 32'd3);
    check("st_gap1", 32'(acc[1] - acc[0]), 32'd11);
    check("st_gap2", 32'(acc[2] - acc[1]), 32'd11);
    check("st_en_total", 32'(enTotal), 32'd27);

    // Reset while draining: everything clears at once and no result appears.
    applyStimulus(tbl[0], 1'b1, "rd");
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) ifc3.i_valid = 1'b0;
    end
    check("rd_pre_en", 32'(ifc3.o_tree_enable), 32'd1);
    check("rd_pre_d0", 32'(ifc3.o_data_a0), 32'd20);
    rst = 1'b1;
    #1;
    check("rd_busy", 32'(ifc3.o_busy), 32'd0);
    check("rd_en", 32'(ifc3.o_tree_enable), 32'd0);
    check("rd_data", 32'(outVec3()), 32'd0);
    check("rd_valid", 32'(ifc3.o_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rd_ready_low", 32'(ifc3.o_ready), 32'd0);
    vSeen = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (ifc3.o_valid) vSeen++;
    end
    check("rd_no_valid", 32'(vSeen), 32'd0);
    check("rd_ready_high", 32'(ifc3.o_ready), 32'd1);
    applyStimulus(tbl[2], 1'b1, "rd_next");
    collect(1'b0, none, vc, en, busy);
    check("rd_next_cycle", 32'(vc), 32'd10);
    checkOutput(tbl[2], outVec3(), "rd_next");

    // Single-stage tree build.
    @(negedge clk);
    ifc1.i_data_a0 = 1; ifc1.i_data_a1 = 2; ifc1.i_data_a2 = 3;
    ifc1.i_data_a3 = 4; ifc1.i_data_a4 = 5; ifc1.i_data_a5 = 6;
    ifc1.i_valid = 1'b1; ifc1.i_ready = 1'b1;
    check("l1_ready", 32'(ifc1.o_ready), 32'd1);
    vc = -1; en = 0;
    for (int n = 1; n <= 30 && vc < 0; n++) begin
      @(negedge clk);
      if (n == 1) ifc1.i_valid = 1'b0;
      if (ifc1.o_tree_enable) en++;
      if (ifc1.o_valid) vc = n;
    end
    check("l1_valid_cycle", 32'(vc), 32'd8);
    check("l1_en_cycles", 32'(en), 32'd7);
    checkOutput(tbl[0], outVec1(), "l1");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
